// File: rtl/elc3_control_if.sv
// Control bundle between the eLC-3 sequencer and its datapath.
// Latency: n/a (wires only); the sequencer drives controls registered, one per state.
// Backpressure: none on this bundle; memory completion arrives on Mem_R.
interface elc3_control_if;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;
    logic        Mem_R;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX;
    logic        DRMUX, SR1MUX, ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic [1:0]  ALUK;
    logic        MIO_EN, Mem_CE, Mem_OE, Mem_WE;
    logic [5:0]  State;

    // Controller side.
    modport master (
        input  Run, Continue, IR, BEN, Mem_R,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output MIO_EN, Mem_CE, Mem_OE, Mem_WE, State
    );

    // Datapath / board side.
    modport slave (
        output Run, Continue, IR, BEN, Mem_R,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  MIO_EN, Mem_CE, Mem_OE, Mem_WE, State
    );
endinterface

// File: rtl/elc3_control.sv
// Moore sequencer for the eLC-3: fetch / decode / execute of an LC-3 subset.
// Latency: 4 cycles fetch+decode, 1-3 execute cycles; controls are registered per state.
// Backpressure: memory states hold while Mem_R=0; pause states hold on Continue.
module elc3_control #(
    parameter bit PAUSE_EACH = 1'b0
) (
    input  logic          Clk,
    input  logic          Reset,
    elc3_control_if.master bus
);

    // Bit 6 separates HALTED from BR, which both show State code 0.
    typedef enum logic [6:0] {
        S_BR     = 7'd0,
        S_ADD    = 7'd1,
        S_LDA    = 7'd2,
        S_STA    = 7'd3,
        S_AND    = 7'd5,
        S_NOT    = 7'd9,
        S_JMP    = 7'd12,
        S_LEA    = 7'd14,
        S_STW    = 7'd16,
        S_F1     = 7'd18,
        S_BRT    = 7'd22,
        S_STD    = 7'd23,
        S_LDR    = 7'd25,
        S_LDW    = 7'd27,
        S_DEC    = 7'd32,
        S_F2     = 7'd33,
        S_F3     = 7'd35,
        S_P1     = 7'd36,
        S_P2     = 7'd37,
        S_HALTED = 7'd64
    } state_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mio_en, mem_ce, mem_oe, mem_we;
    } ctl_t;

    // Where an instruction goes once it has finished executing.
    localparam state_t S_DONE = PAUSE_EACH ? S_P1 : S_F1;

    state_t st;
    ctl_t   ctl;

    function automatic state_t next_state(state_t s, logic run, logic cont,
                                          logic [3:0] op, logic ben, logic mem_r);
        case (s)
            S_HALTED: return run ? S_F1 : S_HALTED;
            S_F1:     return S_F2;
            S_F2:     return mem_r ? S_F3 : S_F2;
            S_F3:     return S_DEC;
            S_DEC: begin
                case (op)
                    4'b0001: return S_ADD;
                    4'b0101: return S_AND;
                    4'b1001: return S_NOT;
                    4'b0000: return S_BR;
                    4'b1100: return S_JMP;
                    4'b0010: return S_LDA;
                    4'b0011: return S_STA;
                    4'b1110: return S_LEA;
                    4'b1101: return S_P1;
                    default: return S_DONE;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BRT, S_JMP, S_LDW, S_LEA: return S_DONE;
            S_BR:     return ben ? S_BRT : S_DONE;
            S_LDA:    return S_LDR;
            S_LDR:    return mem_r ? S_LDW : S_LDR;
            S_STA:    return S_STD;
            S_STD:    return S_STW;
            S_STW:    return mem_r ? S_DONE : S_STW;
            S_P1:     return cont ? S_P2 : S_P1;
            S_P2:     return cont ? S_P2 : S_F1;
            default:  return S_HALTED;
        endcase
    endfunction

    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_F1: begin
                c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00;
            end
            S_F2, S_LDR: begin
                c.mem_ce = 1'b1; c.mem_oe = 1'b1; c.mio_en = 1'b1; c.ld_mdr = 1'b1;
            end
            S_F3: begin
                c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
            end
            S_DEC: c.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                c.sr1mux = 1'b1; c.drmux = 1'b0; c.gate_alu = 1'b1;
                c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.aluk = (s == S_ADD) ? 2'b00 : ((s == S_AND) ? 2'b01 : 2'b10);
            end
            S_BRT: begin
                c.addr1mux = 1'b0; c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1;
            end
            S_JMP: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b00;
                c.pcmux = 2'b10; c.ld_pc = 1'b1;
            end
            S_LDA, S_STA: begin
                c.addr1mux = 1'b0; c.addr2mux = 2'b10; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            S_LDW: begin
                c.gate_mdr = 1'b1; c.drmux = 1'b0; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            S_STD: begin
                c.sr1mux = 1'b0; c.aluk = 2'b11; c.gate_alu = 1'b1;
                c.ld_mdr = 1'b1; c.mio_en = 1'b0;
            end
            S_STW: begin
                c.mem_ce = 1'b1; c.mem_we = 1'b1;
            end
            S_LEA: begin
                c.addr1mux = 1'b0; c.addr2mux = 2'b10; c.gate_marmux = 1'b1;
                c.drmux = 1'b0; c.ld_reg = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // State and output registers; controls are decoded from the next state so they
    // always match the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            st  <= S_HALTED;
            ctl <= '0;
        end else begin
            st  <= next_state(st, bus.Run, bus.Continue, bus.IR[15:12], bus.BEN, bus.Mem_R);
            ctl <= decode(next_state(st, bus.Run, bus.Continue, bus.IR[15:12], bus.BEN, bus.Mem_R));
        end
    end

    // Operand fields of IR are consumed by the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^bus.IR[11:0];

    assign bus.State      = st[5:0];
    assign bus.LD_MAR     = ctl.ld_mar;
    assign bus.LD_MDR     = ctl.ld_mdr;
    assign bus.LD_IR      = ctl.ld_ir;
    assign bus.LD_BEN     = ctl.ld_ben;
    assign bus.LD_REG     = ctl.ld_reg;
    assign bus.LD_CC      = ctl.ld_cc;
    assign bus.LD_PC      = ctl.ld_pc;
    assign bus.GatePC     = ctl.gate_pc;
    assign bus.GateMDR    = ctl.gate_mdr;
    assign bus.GateALU    = ctl.gate_alu;
    assign bus.GateMARMUX = ctl.gate_marmux;
    assign bus.PCMUX      = ctl.pcmux;
    assign bus.DRMUX      = ctl.drmux;
    assign bus.SR1MUX     = ctl.sr1mux;
    assign bus.ADDR1MUX   = ctl.addr1mux;
    assign bus.ADDR2MUX   = ctl.addr2mux;
    assign bus.ALUK       = ctl.aluk;
    assign bus.MIO_EN     = ctl.mio_en;
    assign bus.Mem_CE     = ctl.mem_ce;
    assign bus.Mem_OE     = ctl.mem_oe;
    assign bus.Mem_WE     = ctl.mem_we;

endmodule
